arm_decode_issue: RTL and testbench
===================================

# arm_decode_issue

Decode-and-issue stage between instruction fetch and execute in the ARM pipelined core. Accepts one fetched instruction at a time, extracts register addresses and drives the read/scoreboard port of the register file. Holds the instruction while the register file's `stall` (busy bit on any source, destination or PC) is high. Once operands are clean, it claims the destination by pulsing `set_write_bit` and presents the decoded instruction and operands to execute under a valid/ready handshake.

## Interface
- `NOP_INSTR`, default 32'hE1A00000: word substituted for flushed or undefined slots in `ex_instr`.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `if_valid`  in  1  fetch holds an instruction.
- `if_ready`  out  1  stage accepts the instruction this cycle.
- `if_instr`  in  32  instruction word.
- `if_pc`  in  32  address of `if_instr`.
- `flush`  in  1  execute redirect; discard held instruction.
- `read_1`, `read_2`, `read_3`, `read_4`  out  1 each  register-file read enables (Rn, Rm, Rs, Rd).
- `src1_add`, `src2_add`, `src3_add`, `dest_add`  out  4 each  Rn, Rm, Rs, Rd addresses.
- `set_write_bit`  out  1  one-cycle pulse that marks `dest_add` busy.
- `stall`  in  1  register-file busy indication for the addressed registers.
- `out_src1`..`out_src4`  in  32 each  register-file read data.
- `ex_valid`  out  1  decoded instruction presented.
- `ex_ready`  in  1  execute accepts.
- `ex_instr`, `ex_pc`  out  32 each  instruction word and its PC.
- `ex_class`  out  2  00 data-processing, 01 load/store, 10 branch, 11 undefined.
- `ex_op1`, `ex_op2`, `ex_op3`, `ex_op4`  out  32 each  latched Rn, Rm, Rs, Rd values.
- `ex_wb`  out  1  instruction writes Rd.

## Operation
- Class by bits[27:25]:
  - 000/001 → DP.
  - 010/011 → LS.
  - 101 → branch.
  - Anything else → undefined.
- Read enables:
  - `read_1`: DP except MOV/MVN (opcodes 1101/1111), and all LS.
  - `read_2`: DP with bit25=0, and LS with bit25=1.
  - `read_3`: DP with bit25=0 and bit4=1 (register-specified shift).
  - `read_4`: LS store (bit20=0).
  - Branch and undefined assert no read enable.
- `ex_wb`:
  - DP except opcodes 1000–1011.
  - LS load (bit20=1).
  - Branch (with `dest_add` forced to 15).
  - Undefined: 0.
- States:
  - EMPTY: `if_ready`=1. On `if_valid` → capture `if_instr`/`if_pc` → READ.
  - READ: decode, drive addresses and enables. `stall`=1 → WAIT. `stall`=0 → latch `out_src*` into `ex_op*`, pulse `set_write_bit` if `ex_wb` → ISSUE.
  - WAIT: keep driving the same addresses and enables every cycle. First cycle with `stall`=0 → same actions as READ's exit → ISSUE.
  - ISSUE: `ex_valid`=1. On `ex_ready`: if `if_valid` → capture the next instruction → READ (back-to-back), else → EMPTY.
- `if_ready` = (state==EMPTY) | (state==ISSUE & `ex_ready`).
- `flush` in any state → EMPTY next cycle.
  - No `set_write_bit` pulse in the flush cycle.
  - `ex_valid` is 0 next cycle.
  - `if_instr` offered in the flush cycle is not captured.
- Reset (`rst_n`=0 at edge) → EMPTY; overrides `flush`.

## Timing
- Reset values:
  - All outputs 0, except `ex_instr`=`NOP_INSTR` and `if_ready`=1.
  - `ex_class`=11.
- Best-case latency: accept at edge N → READ in cycle N+1 → `ex_valid` high in cycle N+2.
- `set_write_bit` is high for exactly one cycle: the cycle of the READ/WAIT → ISSUE transition, with `dest_add` stable.
- `ex_*` outputs are held constant while `ex_valid` & !`ex_ready`.
- Read enables and addresses are registered-decode outputs and are stable throughout READ/WAIT.
- Read enables are 0 in EMPTY and ISSUE.
- Throughput: one instruction per 2 cycles without stall.

## Structure
- Shared package `arm_core_pkg`:
  - class encodings and state enum.
  - opcode constants (MOV, MVN, TST–CMN range).
  - `NOP_INSTR` default.
- One natural sub-module: `arm_field_decode`, purely combinational, instruction → class, addresses, read enables, `ex_wb`.
- The FSM and issue register stay in the top.

## Test plan
- 32'hE0812003 (ADD R2,R1,R3), R1=1, R3=3, `stall`=0 → READ: `read_1`=`read_2`=1, `src1_add`=1, `src2_add`=3. Next cycle: `ex_valid`, `ex_op1`=1, `ex_op2`=3, `dest_add`=2, one-cycle `set_write_bit`.
- Same ADD with `stall` held 1 for 3 cycles → WAIT for 3 cycles. No `set_write_bit` until `stall` drops. `ex_valid` rises 1 cycle after `stall`=0.
- 32'hE5812000 (STR R2,[R1]) → `read_1`=`read_4`=1, `ex_wb`=0, no `set_write_bit` pulse, `ex_class`=01.
- 32'hEA000004 (B) → no read enables, `dest_add`=15, `set_write_bit` pulse, `ex_class`=10.
- `ex_ready`=0 for 4 cycles in ISSUE → `ex_*` unchanged, `if_ready`=0. Then `ex_ready`=1 with `if_valid`=1 → next instruction captured the same edge.
- `flush` asserted during WAIT, then `rst_n`=0 during ISSUE → EMPTY next cycle in both cases, `ex_valid`=0, no `set_write_bit`.

Source files
------------

// File: rtl/arm_core_pkg.sv
// Shared types and constants for the ARM core decode/issue slice.
package arm_core_pkg;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'hE1A00000;

    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMN = 4'b1011;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;
    localparam logic [3:0] PC_REG = 4'd15;

    typedef enum logic [1:0] {
        CLS_DP  = 2'b00,
        CLS_LS  = 2'b01,
        CLS_BR  = 2'b10,
        CLS_UND = 2'b11
    } instr_class_e;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_READ,
        ST_WAIT,
        ST_ISSUE
    } issue_state_e;

    typedef struct packed {
        instr_class_e cls;
        logic [3:0]   src1;
        logic [3:0]   src2;
        logic [3:0]   src3;
        logic [3:0]   dest;
        logic         rd1;
        logic         rd2;
        logic         rd3;
        logic         rd4;
        logic         wb;
    } decode_t;

endpackage

// File: rtl/arm_field_decode.sv
// Combinational field decode: instruction word to class, register addresses,
// read enables and write-back flag.
module arm_field_decode
    import arm_core_pkg::*;
(
    input  logic [31:0] instr,
    output decode_t     dec
);

    logic       is_dp;
    logic       is_ls;
    logic       is_br;
    logic [3:0] opcode;
    logic       mov_like;
    logic       test_like;
    logic       unused_bits;

    assign opcode      = instr[24:21];
    assign unused_bits = &{1'b0, instr[31:28], instr[7:5]};

    always_comb begin
        is_dp = 1'b0;
        is_ls = 1'b0;
        is_br = 1'b0;
        unique case (instr[27:25])
            3'b000, 3'b001: is_dp = 1'b1;
            3'b010, 3'b011: is_ls = 1'b1;
            3'b101:         is_br = 1'b1;
            default:        ;
        endcase
    end

    assign mov_like  = (opcode == OP_MOV) || (opcode == OP_MVN);
    assign test_like = (opcode >= OP_TST) && (opcode <= OP_CMN);

    always_comb begin
        dec      = '0;
        dec.cls  = is_dp ? CLS_DP : is_ls ? CLS_LS : is_br ? CLS_BR : CLS_UND;
        dec.src1 = instr[19:16];
        dec.src2 = instr[3:0];
        dec.src3 = instr[11:8];
        dec.dest = is_br ? PC_REG : instr[15:12];
        dec.rd1  = (is_dp && !mov_like) || is_ls;
        dec.rd2  = (is_dp && !instr[25]) || (is_ls && instr[25]);
        dec.rd3  = is_dp && !instr[25] && instr[4];
        dec.rd4  = is_ls && !instr[20];
        dec.wb   = (is_dp && !test_like) || (is_ls && instr[20]) || is_br;
    end

endmodule

// File: rtl/arm_decode_issue.sv
// Decode-and-issue stage: holds one instruction, waits on register-file
// busy bits, claims the destination and hands off to execute.
module arm_decode_issue
    import arm_core_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    input  logic        flush,
    output logic        read_1,
    output logic        read_2,
    output logic        read_3,
    output logic        read_4,
    output logic [3:0]  src1_add,
    output logic [3:0]  src2_add,
    output logic [3:0]  src3_add,
    output logic [3:0]  dest_add,
    output logic        set_write_bit,
    input  logic        stall,
    input  logic [31:0] out_src1,
    input  logic [31:0] out_src2,
    input  logic [31:0] out_src3,
    input  logic [31:0] out_src4,
    output logic        ex_valid,
    input  logic        ex_ready,
    output logic [31:0] ex_instr,
    output logic [31:0] ex_pc,
    output logic [1:0]  ex_class,
    output logic [31:0] ex_op1,
    output logic [31:0] ex_op2,
    output logic [31:0] ex_op3,
    output logic [31:0] ex_op4,
    output logic        ex_wb
);

    issue_state_e state, state_nxt;
    decode_t      dec_in, dec_q;
    logic [31:0]  instr_q, pc_q;
    logic         in_read;
    logic         accept;
    logic         operands_ok;

    arm_field_decode u_decode (
        .instr (if_instr),
        .dec   (dec_in)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_EMPTY;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_EMPTY: if (if_valid) state_nxt = ST_READ;
            ST_READ,
            ST_WAIT:  state_nxt = stall ? ST_WAIT : ST_ISSUE;
            ST_ISSUE: if (ex_ready) state_nxt = if_valid ? ST_READ : ST_EMPTY;
            default:  state_nxt = ST_EMPTY;
        endcase
        if (flush) state_nxt = ST_EMPTY;
    end

    always_comb begin
        in_read       = (state == ST_READ) || (state == ST_WAIT);
        if_ready      = (state == ST_EMPTY) || ((state == ST_ISSUE) && ex_ready);
        ex_valid      = (state == ST_ISSUE);
        accept        = if_valid && if_ready && !flush && rst_n;
        // Operand latch and destination claim share one condition so the
        // busy bit is set exactly when execute will see the instruction.
        operands_ok   = in_read && !stall && !flush && rst_n;
        set_write_bit = operands_ok && dec_q.wb;
        read_1        = in_read && dec_q.rd1;
        read_2        = in_read && dec_q.rd2;
        read_3        = in_read && dec_q.rd3;
        read_4        = in_read && dec_q.rd4;
    end

    assign src1_add = dec_q.src1;
    assign src2_add = dec_q.src2;
    assign src3_add = dec_q.src3;
    assign dest_add = dec_q.dest;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dec_q    <= '0;
            instr_q  <= '0;
            pc_q     <= '0;
            ex_instr <= NOP_INSTR;
            ex_pc    <= '0;
            ex_class <= CLS_UND;
            ex_op1   <= '0;
            ex_op2   <= '0;
            ex_op3   <= '0;
            ex_op4   <= '0;
            ex_wb    <= 1'b0;
        end else begin
            if (accept) begin
                dec_q   <= dec_in;
                instr_q <= if_instr;
                pc_q    <= if_pc;
            end
            if (operands_ok) begin
                ex_instr <= (dec_q.cls == CLS_UND) ? NOP_INSTR : instr_q;
                ex_pc    <= pc_q;
                ex_class <= dec_q.cls;
                ex_op1   <= out_src1;
                ex_op2   <= out_src2;
                ex_op3   <= out_src3;
                ex_op4   <= out_src4;
                ex_wb    <= dec_q.wb;
            end else if (flush) begin
                ex_instr <= NOP_INSTR;
            end
        end
    end

endmodule

// File: tb/tb_arm_decode_issue.sv
// Bench for arm_decode_issue: directed walk-through of the main scenarios,
// then randomized traffic against a queue-based reference model.
module tb_arm_decode_issue;

    localparam logic [31:0] NOP = 32'hE1A00000;
    localparam logic [31:0] I_ADD = 32'hE0812003;
    localparam logic [31:0] I_STR = 32'hE5812000;
    localparam logic [31:0] I_B   = 32'hEA000004;

    logic        clk = 1'b0;
    logic        rst_n, if_valid, if_ready, flush, stall, ex_valid, ex_ready, ex_wb;
    logic [31:0] if_instr, if_pc, ex_instr, ex_pc;
    logic        read_1, read_2, read_3, read_4, set_write_bit;
    logic [3:0]  src1_add, src2_add, src3_add, dest_add;
    logic [31:0] out_src1, out_src2, out_src3, out_src4;
    logic [31:0] ex_op1, ex_op2, ex_op3, ex_op4;
    logic [1:0]  ex_class;

    logic [31:0] regs [16];

    typedef struct {
        logic [31:0] instr, pc, op1, op2, op3, op4;
        logic [1:0]  cls;
        logic        wb;
        logic [3:0]  dest;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;
    logic mon_on = 1'b0;

    always #5 clk = ~clk;

    assign out_src1 = read_1 ? regs[src1_add] : '0;
    assign out_src2 = read_2 ? regs[src2_add] : '0;
    assign out_src3 = read_3 ? regs[src3_add] : '0;
    assign out_src4 = read_4 ? regs[dest_add] : '0;

    arm_decode_issue #(.NOP_INSTR(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc), .flush(flush),
        .read_1(read_1), .read_2(read_2), .read_3(read_3), .read_4(read_4),
        .src1_add(src1_add), .src2_add(src2_add), .src3_add(src3_add), .dest_add(dest_add),
        .set_write_bit(set_write_bit), .stall(stall),
        .out_src1(out_src1), .out_src2(out_src2), .out_src3(out_src3), .out_src4(out_src4),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_instr(ex_instr), .ex_pc(ex_pc),
        .ex_class(ex_class), .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_op3(ex_op3),
        .ex_op4(ex_op4), .ex_wb(ex_wb)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t predict(input logic [31:0] w, input logic [31:0] pc);
        exp_t e;
        logic [2:0] k;
        logic [3:0] op;
        logic dp, ls, br, r1, r2, r3, r4;
        k  = w[27:25];
        op = w[24:21];
        dp = (k == 3'd0) || (k == 3'd1);
        ls = (k == 3'd2) || (k == 3'd3);
        br = (k == 3'd5);
        r1 = (dp && op != 4'd13 && op != 4'd15) || ls;
        r2 = (dp && !w[25]) || (ls && w[25]);
        r3 = dp && !w[25] && w[4];
        r4 = ls && !w[20];
        e.cls   = dp ? 2'd0 : ls ? 2'd1 : br ? 2'd2 : 2'd3;
        e.dest  = br ? 4'd15 : w[15:12];
        e.wb    = (dp && !(op >= 4'd8 && op <= 4'd11)) || (ls && w[20]) || br;
        e.op1   = r1 ? regs[w[19:16]] : 32'd0;
        e.op2   = r2 ? regs[w[3:0]] : 32'd0;
        e.op3   = r3 ? regs[w[11:8]] : 32'd0;
        e.op4   = r4 ? regs[e.dest] : 32'd0;
        e.instr = (e.cls == 2'd3) ? NOP : w;
        e.pc    = pc;
        return e;
    endfunction

    // Monitor: samples after the driver has settled this cycle's inputs.
    initial begin
        exp_t e;
        int pulses = 0;
        logic prev_vld = 1'b0, prev_rdy = 1'b0, prev_flush = 1'b0;
        logic [32*6+2:0] snap, prev_snap;
        prev_snap = '0;
        forever begin
            @(negedge clk);
            #2;
            snap = {ex_instr, ex_pc, ex_op1, ex_op2, ex_op3, ex_op4, ex_class, ex_wb};
            if (mon_on) begin
                if (prev_flush) chk("valid_after_flush", ex_valid, 0);
                if (prev_vld && !prev_rdy && !prev_flush && ex_valid)
                    chk("hold_ex_fields", (snap == prev_snap) ? 1 : 0, 1);
                if (flush) begin
                    chk("swb_in_flush", set_write_bit, 0);
                    pulses = 0;
                end else begin
                    if (set_write_bit) begin
                        if (sbq.size() == 0) chk("swb_no_instr", 1, 0);
                        else chk("swb_dest", dest_add, sbq[0].dest);
                        pulses++;
                    end
                    if (ex_valid && ex_ready) begin
                        if (sbq.size() == 0) begin
                            chk("unexpected_issue", 1, 0);
                        end else begin
                            e = sbq.pop_front();
                            chk("ex_instr", ex_instr, e.instr);
                            chk("ex_pc", ex_pc, e.pc);
                            chk("ex_class", ex_class, e.cls);
                            chk("ex_op1", ex_op1, e.op1);
                            chk("ex_op2", ex_op2, e.op2);
                            chk("ex_op3", ex_op3, e.op3);
                            chk("ex_op4", ex_op4, e.op4);
                            chk("ex_wb", ex_wb, e.wb);
                            chk("swb_pulses", pulses, e.wb);
                        end
                        pulses = 0;
                    end
                end
            end
            prev_vld   = mon_on && ex_valid;
            prev_rdy   = ex_ready;
            prev_flush = mon_on && flush;
            prev_snap  = snap;
        end
    end

    initial begin
        rst_n = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0;
        flush = 1'b0; stall = 1'b0; ex_ready = 1'b0;
        for (int i = 0; i < 16; i++) regs[i] = $urandom;
        regs[1] = 32'd1; regs[2] = 32'd2; regs[3] = 32'd3;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_if_ready", if_ready, 1);
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_ex_instr", ex_instr, NOP);
        chk("rst_ex_class", ex_class, 2'b11);
        chk("rst_reads", {read_1, read_2, read_3, read_4}, 0);
        chk("rst_swb", set_write_bit, 0);
        chk("rst_dest", dest_add, 0);
        chk("rst_ex_op1", ex_op1, 0);
        chk("rst_ex_wb", ex_wb, 0);

        // ADD: one cycle in READ, then issue held by execute for 4 cycles
        @(negedge clk); rst_n = 1'b1; if_valid = 1'b1; if_instr = I_ADD; if_pc = 32'h100;
        #1 chk("add_accept", if_ready, 1);
        @(negedge clk); if_valid = 1'b0;
        #1;
        chk("add_reads", {read_1, read_2, read_3, read_4}, 4'b1100);
        chk("add_src1", src1_add, 1);
        chk("add_src2", src2_add, 3);
        chk("add_swb", set_write_bit, 1);
        chk("add_read_valid", ex_valid, 0);
        @(negedge clk); #1;
        chk("add_valid", ex_valid, 1);
        chk("add_op1", ex_op1, 1);
        chk("add_op2", ex_op2, 3);
        chk("add_dest", dest_add, 2);
        chk("add_swb_once", set_write_bit, 0);
        chk("add_issue_reads", read_1, 0);
        chk("add_class", ex_class, 0);
        chk("add_wb", ex_wb, 1);
        chk("add_instr", ex_instr, I_ADD);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("hold_op1", ex_op1, 1);
            chk("hold_instr", ex_instr, I_ADD);
            chk("hold_if_ready", if_ready, 0);
            chk("hold_valid", ex_valid, 1);
        end
        @(negedge clk); ex_ready = 1'b1; if_valid = 1'b1; if_instr = I_STR; if_pc = 32'h104;
        #1 chk("b2b_if_ready", if_ready, 1);

        // STR
        @(negedge clk); ex_ready = 1'b0; if_valid = 1'b0;
        #1;
        chk("str_valid_low", ex_valid, 0);
        chk("str_reads", {read_1, read_2, read_3, read_4}, 4'b1001);
        chk("str_swb", set_write_bit, 0);
        @(negedge clk); #1;
        chk("str_class", ex_class, 1);
        chk("str_wb", ex_wb, 0);
        chk("str_op4", ex_op4, 2);
        chk("str_op1", ex_op1, 1);
        ex_ready = 1'b1; if_valid = 1'b1; if_instr = I_B; if_pc = 32'h108;

        // Branch
        @(negedge clk); ex_ready = 1'b0; if_valid = 1'b0;
        #1;
        chk("b_reads", {read_1, read_2, read_3, read_4}, 0);
        chk("b_dest", dest_add, 15);
        chk("b_swb", set_write_bit, 1);
        @(negedge clk); #1;
        chk("b_class", ex_class, 2);
        chk("b_wb", ex_wb, 1);
        chk("b_valid", ex_valid, 1);
        ex_ready = 1'b1; if_valid = 1'b1; if_instr = I_ADD; stall = 1'b1;

        // ADD with stall: READ plus 3 WAIT cycles
        @(negedge clk); ex_ready = 1'b0; if_valid = 1'b0;
        #1 chk("stall_read_swb", set_write_bit, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("wait_swb", set_write_bit, 0);
            chk("wait_valid", ex_valid, 0);
            chk("wait_read_1", read_1, 1);
            chk("wait_src2", src2_add, 3);
        end
        @(negedge clk); stall = 1'b0;
        #1;
        chk("unstall_swb", set_write_bit, 1);
        chk("unstall_valid", ex_valid, 0);
        @(negedge clk); #1;
        chk("unstall_issue", ex_valid, 1);
        chk("unstall_op2", ex_op2, 3);
        ex_ready = 1'b1; if_valid = 1'b1; stall = 1'b1;

        // flush during WAIT with operands just becoming clean
        @(negedge clk); if_valid = 1'b0; ex_ready = 1'b0;
        @(negedge clk); flush = 1'b1; stall = 1'b0; if_valid = 1'b1; if_instr = I_B;
        #1 chk("flush_swb", set_write_bit, 0);
        @(negedge clk); flush = 1'b0; if_valid = 1'b0;
        #1;
        chk("flush_valid", ex_valid, 0);
        chk("flush_if_ready", if_ready, 1);
        chk("flush_reads", {read_1, read_2, read_3, read_4}, 0);
        @(negedge clk); #1;
        chk("flush_no_capture", {ex_valid, read_1, read_2, read_3, read_4}, 0);
        if_valid = 1'b1; if_instr = I_ADD;

        // reset during ISSUE, with flush also high
        @(negedge clk); if_valid = 1'b0;
        @(negedge clk); #1;
        chk("pre_rst_valid", ex_valid, 1);
        rst_n = 1'b0; flush = 1'b1;
        @(negedge clk); rst_n = 1'b1; flush = 1'b0;
        #1;
        chk("issue_rst_valid", ex_valid, 0);
        chk("issue_rst_instr", ex_instr, NOP);
        chk("issue_rst_class", ex_class, 2'b11);
        chk("issue_rst_if_ready", if_ready, 1);
        chk("issue_rst_swb", set_write_bit, 0);
        chk("issue_rst_dest", dest_add, 0);

        // randomized traffic against the scoreboard
        for (int i = 0; i < 16; i++) regs[i] = $urandom;
        mon_on = 1'b1;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            if_valid = ($urandom % 4) != 0;
            if_instr = $urandom;
            if_pc    = $urandom;
            stall    = ($urandom % 3) == 0;
            flush    = ($urandom % 20) == 0;
            ex_ready = flush ? 1'b0 : (($urandom % 3) != 0);
            #1;
            if (flush) sbq.delete();
            else if (if_valid && if_ready) sbq.push_back(predict(if_instr, if_pc));
        end
        @(negedge clk);
        if_valid = 1'b0; flush = 1'b0; stall = 1'b0; ex_ready = 1'b1;
        for (int c = 0; c < 20 && sbq.size() != 0; c++) @(negedge clk);
        chk("drain_timeout", sbq.size(), 0);
        repeat (2) @(negedge clk);
        mon_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
